uart_bus_master: RTL and testbench

Byte-stream-to-memory-bus bridge acting as a second initiator on the SoC memory bus. It takes bytes from the UART receive path, decodes write and read commands, and issues single-word transactions on the same bus signals the CPU drives: mem_addr, mem_wdata, mem_wmask, mem_rstrb and mem_rdata. Read data and write acknowledges go back through the UART transmit path. Bus ownership is requested from an external arbiter, so RAM and peripherals can be loaded and inspected without CPU involvement.

---
 rtl/uart_bus_master.sv | 77 +++++++
 tb/tb_uart_bus_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART byte commands ('W' addr data -> 'K', 'R' addr -> 4 data bytes) to single-word bus transactions
module uart_bus_master #(
  parameter int RD_LAT = 1,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [3:0] {IDLE, ADDR, DATA, REQ, WRITE, READ, RWAIT, SEND, ACK} state_t;
  state_t state, state_n;
  logic is_wr, go, last_byte, timed_out, lat_done;
  logic [1:0] cnt;
  logic [31:0] addr, rdata, tmo, lat;
  logic [7:0] tx_q, cur;
  assign last_byte = rx_valid && cnt == 2'd3;
  assign timed_out = !rx_valid && tmo == 32'(TIMEOUT_CYC - 1);
  assign lat_done = lat == 32'(RD_LAT - 1);
  assign cur = state == ACK ? 8'h4B : rdata[31:24];
  assign tx_start = state inside {SEND, ACK} && go && !tx_busy;
  assign tx_data = tx_start ? cur : tx_q;
  assign bus_req = state inside {REQ, WRITE, READ, RWAIT};
  assign mem_addr = addr & 32'hFFFF_FFFC;
  assign mem_wmask = {4{state == WRITE}};
  assign mem_rstrb = state == READ;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = rx_valid && (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : IDLE;
      ADDR:  state_n = timed_out ? IDLE : !last_byte ? ADDR : is_wr ? DATA : REQ;
      DATA:  state_n = timed_out ? IDLE : last_byte ? REQ : DATA;
      REQ:   state_n = !bus_gnt ? REQ : is_wr ? WRITE : READ;
      WRITE: state_n = ACK;
      READ:  state_n = RWAIT;
      RWAIT: state_n = lat_done ? SEND : RWAIT;
      SEND:  state_n = tx_start && cnt == 2'd3 ? IDLE : SEND;
      ACK:   state_n = tx_start ? IDLE : ACK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      is_wr <= 1'b0;
      go <= 1'b0;
      cnt <= 2'd0;
      tmo <= 32'd0;
      lat <= 32'd0;
      addr <= 32'd0;
      mem_wdata <= 32'd0;
      rdata <= 32'd0;
      tx_q <= 8'd0;
    end else begin
      if (state == IDLE && rx_valid) is_wr <= rx_data == 8'h57;
      cnt <= state == IDLE ? 2'd0 : (state inside {ADDR, DATA} && rx_valid) || (state == SEND && tx_start) ? cnt + 2'd1 : cnt;
      tmo <= state inside {ADDR, DATA} && !rx_valid ? tmo + 32'd1 : 32'd0;
      lat <= state == RWAIT ? lat + 32'd1 : 32'd0;
      go <= state inside {SEND, ACK} && !tx_start;
      if (state == ADDR && rx_valid) addr <= {addr[23:0], rx_data};
      if (state == DATA && rx_valid) mem_wdata <= {mem_wdata[23:0], rx_data};
      rdata <= state == RWAIT && lat_done ? mem_rdata : tx_start ? rdata << 8 : rdata;
      if (tx_start) tx_q <= cur;
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed, table-driven and randomized checks of uart_bus_master against a word-memory reference
module tb_uart_bus_master;
  logic clk = 0, resetn = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, tx_start, tx_busy, bus_req, bus_gnt, mem_rstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0] mem_wmask;
  logic gnt_manual = 0, gnt_val = 0, gnt_auto = 0, force_busy = 0, have_tx = 0;
  int gnt_delay = 0, gcnt = 0, busy_max = 0, bcnt = 0;
  int tests = 0, fails = 0, n_wr = 0, n_rd = 0, n_req = 0;
  logic [31:0] last_wa = 0, last_wd = 0, last_ra = 0;
  logic [7:0] txq[$];
  logic [7:0] last_tx = 0;
  logic [31:0] ram [logic [31:0]];
  logic [31:0] ref_ram [logic [31:0]];
  typedef struct {
    logic wr;
    logic [31:0] addr, data, exp_addr, exp_rd;
  } vec_t;
  vec_t vt [9];
  uart_bus_master #(.RD_LAT(1), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign bus_gnt = gnt_manual ? gnt_val : gnt_auto;
  assign tx_busy = force_busy || bcnt != 0;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk or negedge resetn)
    if (!resetn) bcnt <= 0;
    else if (tx_start) bcnt <= int'($urandom_range(0, busy_max));
    else if (bcnt != 0) bcnt <= bcnt - 1;
  always @(posedge clk)
    if (mem_rstrb) mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
  always @(negedge clk) begin
    gcnt = bus_req ? gcnt + 1 : 0;
    gnt_auto = bus_req && gcnt > gnt_delay;
    if (bus_req) n_req++;
    if (mem_wmask != 4'h0) begin
      chk("wmask_full", mem_wmask, 4'hF);
      chk("wr_owned", bus_req, 1'b1);
      n_wr++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
      ram[mem_addr] = mem_wdata;
    end
    if (mem_rstrb) begin
      chk("rd_owned", bus_req, 1'b1);
      n_rd++;
      last_ra = mem_addr;
    end
    if (tx_start) begin
      chk("tx_start_not_busy", tx_busy, 1'b0);
      txq.push_back(tx_data);
      last_tx = tx_data;
      have_tx = 1;
    end else if (have_tx && resetn) chk("tx_data_held", tx_data, last_tx);
    if (!resetn) have_tx = 0;
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input int gap);
    send_byte(wr ? 8'h57 : 8'h52);
    for (int k = 0; k < 4; k++) begin
      repeat (gap) @(negedge clk);
      send_byte(a[31-8*k -: 8]);
    end
    if (wr) for (int k = 0; k < 4; k++) send_byte(d[31-8*k -: 8]);
  endtask
  task automatic wait_tx(input int n);
    int b = 0;
    while (txq.size() < n && b < 3000) begin
      @(negedge clk);
      b++;
    end
    chk("tx_count", txq.size(), n);
  endtask
  task automatic chk_outs_zero();
    chk("rst_outs_zero", {tx_data, tx_start, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb}, 96'h0);
  endtask
  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_addr, input logic [31:0] exp_rd, input int gap);
    int w0 = n_wr, r0 = n_rd;
    txq.delete();
    send_cmd(wr, a, d, gap);
    wait_tx(wr ? 1 : 4);
    repeat (4) @(negedge clk);
    chk("tx_total", txq.size(), wr ? 1 : 4);
    chk("wr_strobes", n_wr - w0, wr ? 1 : 0);
    chk("rd_strobes", n_rd - r0, wr ? 0 : 1);
    if (wr) begin
      chk("wr_addr", last_wa, exp_addr);
      chk("wr_data", last_wd, d);
      chk("ack_byte", txq[0], 8'h4B);
    end else begin
      chk("rd_addr", last_ra, exp_addr);
      for (int k = 0; k < 4; k++) chk("rd_byte", txq[k], exp_rd[31-8*k -: 8]);
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, r0, q0, b;
    logic [31:0] a, d, al, e;
    logic [7:0] g;
    logic wr;
    vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0};
    vt[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0010, 32'hDEAD_BEEF};
    vt[2] = '{1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0000_0010, 32'h0};
    vt[3] = '{1'b0, 32'h0000_0012, 32'h0,         32'h0000_0010, 32'h1234_5678};
    vt[4] = '{1'b1, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'hFFFF_FFFC, 32'h0};
    vt[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'hA5A5_5A5A};
    vt[6] = '{1'b0, 32'h0000_0040, 32'h0,         32'h0000_0040, 32'h0};
    vt[7] = '{1'b1, 32'h0000_0040, 32'h0000_0001, 32'h0000_0040, 32'h0};
    vt[8] = '{1'b0, 32'h0000_0041, 32'h0,         32'h0000_0040, 32'h0000_0001};
    #2 resetn = 0;
    #1 chk_outs_zero();
    repeat (3) @(negedge clk);
    resetn = 1;
    gnt_manual = 1;
    gnt_val = 1;
    txq.delete();
    w0 = n_wr;
    send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    chk("w_req_rise", bus_req, 1'b1);
    chk("w_no_early_strobe", mem_wmask, 4'h0);
    @(negedge clk);
    chk("w_strobe", mem_wmask, 4'hF);
    chk("w_addr", mem_addr, 32'h10);
    chk("w_data", mem_wdata, 32'hDEAD_BEEF);
    chk("w_req_held", bus_req, 1'b1);
    @(negedge clk);
    chk("w_req_fall", bus_req, 1'b0);
    chk("w_strobe_end", mem_wmask, 4'h0);
    chk("w_tx_wait", tx_start, 1'b0);
    @(negedge clk);
    chk("w_ack_start", tx_start, 1'b1);
    chk("w_ack_data", tx_data, 8'h4B);
    @(negedge clk);
    chk("w_ack_single", tx_start, 1'b0);
    repeat (3) @(negedge clk);
    chk("w_strobe_count", n_wr - w0, 1);
    chk("w_tx_total", txq.size(), 1);
    gnt_manual = 0;
    for (int i = 0; i < 9; i++) run_cmd(vt[i].wr, vt[i].addr, vt[i].data, vt[i].exp_addr, vt[i].exp_rd, 0);
    gnt_manual = 1;
    gnt_val = 0;
    txq.delete();
    r0 = n_rd;
    send_cmd(1'b0, 32'h10, 32'h0, 0);
    for (int i = 0; i < 20; i++) begin
      chk("gnt_low_req", bus_req, 1'b1);
      chk("gnt_low_no_strobe", mem_rstrb, 1'b0);
      @(negedge clk);
    end
    gnt_val = 1;
    @(negedge clk);
    chk("gnt_strobe_next", mem_rstrb, 1'b1);
    gnt_val = 0;
    wait_tx(4);
    repeat (4) @(negedge clk);
    chk("gnt_rd_count", n_rd - r0, 1);
    for (int k = 0; k < 4; k++) chk("gnt_rd_byte", txq[k], 8'(32'h1234_5678 >> (24 - 8 * k)));
    gnt_manual = 0;
    txq.delete();
    q0 = n_req;
    r0 = n_rd;
    send_byte(8'h52);
    repeat (3) send_byte(8'h00);
    repeat (110) @(negedge clk);
    send_byte(8'h10);
    repeat (20) @(negedge clk);
    chk("tmo_no_req", n_req - q0, 0);
    chk("tmo_no_rd", n_rd - r0, 0);
    chk("tmo_no_tx", txq.size(), 0);
    run_cmd(1'b0, 32'h10, 32'h0, 32'h10, 32'h1234_5678, 0);
    run_cmd(1'b0, 32'h10, 32'h0, 32'h10, 32'h1234_5678, 90);
    txq.delete();
    q0 = n_req;
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (10) @(negedge clk);
    chk("garbage_no_req", n_req - q0, 0);
    chk("garbage_no_tx", txq.size(), 0);
    force_busy = 1;
    r0 = n_rd;
    w0 = n_wr;
    send_cmd(1'b0, 32'h10, 32'h0, 0);
    b = 0;
    while (n_rd == r0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("busy_rd_seen", n_rd - r0, 1);
    repeat (3) @(negedge clk);
    send_cmd(1'b0, 32'h10, 32'h0, 0);
    repeat (35) @(negedge clk);
    chk("busy_held_no_tx", txq.size(), 0);
    force_busy = 0;
    wait_tx(4);
    repeat (30) @(negedge clk);
    chk("busy_tx_total", txq.size(), 4);
    chk("busy_rd_count", n_rd - r0, 1);
    chk("busy_wr_count", n_wr - w0, 0);
    for (int k = 0; k < 4; k++) chk("busy_rd_byte", txq[k], 8'(32'h1234_5678 >> (24 - 8 * k)));
    gnt_manual = 1;
    gnt_val = 0;
    txq.delete();
    send_cmd(1'b0, 32'h10, 32'h0, 0);
    gnt_val = 1;
    @(negedge clk);
    chk("rst_rd_strobe", mem_rstrb, 1'b1);
    @(negedge clk);
    resetn = 0;
    #1 chk_outs_zero();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs_zero();
    end
    resetn = 1;
    gnt_val = 0;
    gnt_manual = 0;
    q0 = n_req;
    repeat (30) @(negedge clk);
    chk("rst_no_tx", txq.size(), 0);
    chk("rst_no_req", n_req - q0, 0);
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      gnt_delay = int'($urandom_range(0, 6));
      busy_max = int'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom);
        if (g != 8'h57 && g != 8'h52) send_byte(g);
      end
      al = a & ~32'h3;
      e = ref_ram.exists(al) ? ref_ram[al] : 32'h0;
      if (wr) ref_ram[al] = d;
      run_cmd(wr, a, d, al, e, int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
